// File: rtl/data_memory_pkg.sv
// Shared types and widths for the data_memory block: FSM state encoding,
// operation kind, bus/counter widths and the access counter preload helper.
package data_memory_pkg;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_t;

    // Preload value so the access lands exactly ACCESS_CYCLES edges after acceptance.
    function automatic logic [CNT_W-1:0] count_load(input int unsigned cycles);
        count_load = CNT_W'(cycles - 32'd1);
    endfunction

endpackage

// File: rtl/data_memory.sv
// Multi-cycle block memory behind the data cache with a busywait handshake.
// Optional DATA_MEMORY_RESET_CLEAR_EN: reset also clears every stored block.
module data_memory
    import data_memory_pkg::*;
#(
    parameter int ACCESS_CYCLES = 5,
    parameter int NUM_BLOCKS    = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              read,
    input  logic              write,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] writedata,
    output logic [DATA_W-1:0] readdata,
    output logic              busywait
);

    state_t            state_r;
    state_t            next_state_s;
    logic [CNT_W-1:0]  count_r;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] wdata_r;
    op_t               op_r;
    logic [DATA_W-1:0] readdata_r;
    logic [DATA_W-1:0] mem_r [NUM_BLOCKS];

    logic              busywait_s;
    logic              accept_s;
    logic              access_s;
    logic              mem_we_s;

    // Next-state and handshake decode; IDLE mirrors the request so the cache never sees a false low.
    always_comb begin
        next_state_s = state_r;
        busywait_s   = 1'b0;
        accept_s     = 1'b0;
        access_s     = 1'b0;
        case (state_r)
            IDLE: begin
                busywait_s = read | write;
                if (read | write) begin
                    accept_s     = 1'b1;
                    next_state_s = BUSY;
                end else begin
                    next_state_s = IDLE;
                end
            end
            BUSY: begin
                busywait_s = 1'b1;
                if (count_r == {CNT_W{1'b0}}) begin
                    access_s     = 1'b1;
                    next_state_s = DONE;
                end else begin
                    next_state_s = BUSY;
                end
            end
            DONE: begin
                busywait_s   = 1'b0;
                next_state_s = IDLE;
            end
            default: begin
                busywait_s   = 1'b0;
                next_state_s = IDLE;
            end
        endcase
    end

    assign mem_we_s = access_s & (op_r == OP_WRITE);

    // State, request latch, countdown and registered read result.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r    <= IDLE;
            count_r    <= {CNT_W{1'b0}};
            addr_r     <= {ADDR_W{1'b0}};
            wdata_r    <= {DATA_W{1'b0}};
            op_r       <= OP_READ;
            readdata_r <= {DATA_W{1'b0}};
        end else begin
            state_r <= next_state_s;
            if (accept_s) begin
                addr_r  <= address;
                wdata_r <= writedata;
                op_r    <= write ? OP_WRITE : OP_READ;
                count_r <= count_load(ACCESS_CYCLES);
            end else if ((state_r == BUSY) && (count_r != {CNT_W{1'b0}})) begin
                count_r <= count_r - CNT_W'(1);
            end
            if (access_s && (op_r == OP_READ)) begin
                readdata_r <= mem_r[addr_r];
            end
        end
    end

`ifdef DATA_MEMORY_RESET_CLEAR_EN
    // Storage array, wiped to zero whenever reset is asserted.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_BLOCKS; i++) begin
                mem_r[i] <= {DATA_W{1'b0}};
            end
        end else if (mem_we_s) begin
            mem_r[addr_r] <= wdata_r;
        end
    end
`else
    // Storage array; contents survive reset (an aborted write never reaches it).
    always_ff @(posedge clock) begin
        if (reset && mem_we_s) begin
            mem_r[addr_r] <= wdata_r;
        end
    end
`endif

    assign readdata = readdata_r;
    assign busywait = busywait_s;

endmodule

// File: tb/tb_data_memory.sv
// Scoreboard bench for data_memory: one instance at ACCESS_CYCLES=5, one at 1.
`timescale 1ns/1ps
module tb_data_memory;

    localparam int AC0 = 5;
    localparam int AC1 = 1;

    logic        clock = 1'b0;
    logic        reset;
    logic        rd   [2];
    logic        wr   [2];
    logic [5:0]  ad   [2];
    logic [31:0] wd   [2];
    logic [31:0] rdat [2];
    logic        bw   [2];

    data_memory #(.ACCESS_CYCLES(AC0), .NUM_BLOCKS(64)) dut0 (
        .clock(clock), .reset(reset), .read(rd[0]), .write(wr[0]),
        .address(ad[0]), .writedata(wd[0]), .readdata(rdat[0]), .busywait(bw[0])
    );

    data_memory #(.ACCESS_CYCLES(AC1), .NUM_BLOCKS(64)) dut1 (
        .clock(clock), .reset(reset), .read(rd[1]), .write(wr[1]),
        .address(ad[1]), .writedata(wd[1]), .readdata(rdat[1]), .busywait(bw[1])
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] data;
        int          busy;
    } exp_t;

    exp_t        sb0 [$];
    exp_t        sb1 [$];
    logic [31:0] mem_m   [2][64];
    bit          known_m [2][64];
    logic [31:0] last_m  [2];
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: what reset does to the readable state of the memory.
    task automatic reset_model();
        for (int i = 0; i < 2; i++) begin
            last_m[i] = 32'h0;
`ifdef DATA_MEMORY_RESET_CLEAR_EN
            for (int a = 0; a < 64; a++) begin
                mem_m[i][a]   = 32'h0;
                known_m[i][a] = 1'b1;
            end
`endif
        end
    endtask

    task automatic scramble(input int i);
        rd[i] = 1'($urandom_range(0, 1));
        wr[i] = 1'($urandom_range(0, 1));
        ad[i] = 6'($urandom_range(0, 63));
        wd[i] = $urandom();
    endtask

    // Issue one request in an IDLE cycle, push its expectation, wait for DONE.
    task automatic issue(input int i, input bit r, input bit w, input logic [5:0] a, input logic [31:0] d);
        exp_t e;
        bit   seen;
        if (w) begin
            mem_m[i][a]   = d;
            known_m[i][a] = 1'b1;
        end else begin
            last_m[i] = mem_m[i][a];
        end
        e.data = last_m[i];
        e.busy = ((i == 0) ? AC0 : AC1) + 1;
        if (i == 0) sb0.push_back(e); else sb1.push_back(e);
        rd[i] = r; wr[i] = w; ad[i] = a; wd[i] = d;
        @(posedge clock); #1;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            scramble(i);
            @(negedge clock);
            if (!bw[i]) seen = 1'b1;
            else begin
                @(posedge clock); #1;
            end
        end
        if (!seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout: dut%0d busywait stuck high, expected completion within 40 cycles", i);
        end
        @(posedge clock); #1;
        rd[i] = 1'b0;
        wr[i] = 1'b0;
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            rd[i] = 1'b0;
            wr[i] = 1'b0;
        end
        #1;
        for (int i = 0; i < 2; i++) begin
            check("reset_readdata", rdat[i], 32'h0);
            check("reset_busywait", {31'b0, bw[i]}, 32'h0);
        end
        reset_model();
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    bit prev  [2];
    bit after [2];
    int cnt   [2];

    // Monitor: a high-to-low busywait edge is a completion; pop and compare.
    always @(negedge clock) begin
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            if (!reset) begin
                prev[i]  = 1'b0;
                after[i] = 1'b0;
                cnt[i]   = 0;
            end else begin
                if (after[i] && (rd[i] || wr[i]))
                    check("done_single_cycle", {31'b0, bw[i]}, 32'h1);
                after[i] = 1'b0;
                if (bw[i]) begin
                    cnt[i]++;
                end else if (prev[i]) begin
                    if (((i == 0) ? sb0.size() : sb1.size()) == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_completion: dut%0d completed with no request outstanding", i);
                    end else begin
                        if (i == 0) e = sb0.pop_front(); else e = sb1.pop_front();
                        check("readdata", rdat[i], e.data);
                        check("busy_cycles", 32'(cnt[i]), 32'(e.busy));
                    end
                    cnt[i]   = 0;
                    after[i] = 1'b1;
                end
                prev[i] = bw[i];
            end
        end
    end

    initial begin
        logic [31:0] v;
        logic [5:0]  a;
        for (int i = 0; i < 2; i++) begin
            rd[i] = 1'b0; wr[i] = 1'b0; ad[i] = 6'h0; wd[i] = 32'h0;
            last_m[i] = 32'h0;
            for (int j = 0; j < 64; j++) begin
                mem_m[i][j]   = 32'h0;
                known_m[i][j] = 1'b0;
            end
        end
        pulse_reset();

        // Single-cycle access instance.
        if (known_m[1][0]) issue(1, 1'b1, 1'b0, 6'h00, 32'h0);
        v = $urandom();
        issue(1, 1'b0, 1'b1, 6'h00, v);
        issue(1, 1'b1, 1'b0, 6'h00, 32'h0);
        issue(1, 1'b1, 1'b1, 6'h21, 32'h0BADF00D);
        issue(1, 1'b1, 1'b0, 6'h21, 32'h0);

        // Write then read back, back to back.
        issue(0, 1'b0, 1'b1, 6'h2A, 32'hDEADBEEF);
        issue(0, 1'b1, 1'b0, 6'h2A, 32'h0);
        issue(0, 1'b0, 1'b1, 6'h05, $urandom());
        issue(0, 1'b1, 1'b0, 6'h05, 32'h0);

        // read and write together behave as a write.
        issue(0, 1'b1, 1'b1, 6'h10, 32'h12345678);
        issue(0, 1'b1, 1'b0, 6'h10, 32'h0);

        // Reset three edges into a write must abort it.
        issue(0, 1'b0, 1'b1, 6'h3F, $urandom());
        rd[0] = 1'b0; wr[0] = 1'b1; ad[0] = 6'h3F; wd[0] = 32'hA5A5A5A5;
        @(posedge clock); #1;
        wr[0] = 1'b0; ad[0] = 6'h00;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        wr[0] = 1'b1;
        #1;
        check("abort_readdata", rdat[0], 32'h0);
        check("abort_busywait_follows_req", {31'b0, bw[0]}, 32'h1);
        wr[0] = 1'b0;
        #1;
        check("abort_busywait_idle", {31'b0, bw[0]}, 32'h0);
        reset_model();
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        issue(0, 1'b1, 1'b0, 6'h3F, 32'h0);

        // Contents across a reset pulse.
        issue(0, 1'b0, 1'b1, 6'h01, 32'hCAFEF00D);
        @(posedge clock); #1;
        pulse_reset();
        issue(0, 1'b1, 1'b0, 6'h01, 32'h0);

        // Randomized traffic.
        for (int n = 0; n < 60; n++) begin
            a = 6'($urandom_range(0, 63));
            if ($urandom_range(0, 1) == 1 && known_m[0][a])
                issue(0, 1'b1, 1'b0, a, 32'h0);
            else
                issue(0, ($urandom_range(0, 7) == 0), 1'b1, a, $urandom());
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clock);
                #1;
            end
        end

        repeat (3) @(posedge clock);
        check("sb0_drained", 32'(sb0.size()), 32'h0);
        check("sb1_drained", 32'(sb1.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/data_memory.md
DATA_MEMORY -- requirements
Module: data_memory

Interface
REQ-001 Parameter ACCESS_CYCLES, default 5: clock edges from request acceptance to completion; legal range 1..15.
REQ-002 Parameter NUM_BLOCKS, default 64: number of 32-bit blocks; equals 2^6.
REQ-003 clock  input  1  sole clock; all state changes on rising edge.
REQ-004 reset  input  1  reset is asynchronous and active-low.
REQ-005 read  input  1  block read request from data cache.
REQ-006 write  input  1  block write-back request from data cache.
REQ-007 address  input  6  block address {tag, index}.
REQ-008 writedata  input  32  block to write.
REQ-009 readdata  output  32  registered block read result.
REQ-010 busywait  output  1  high while a request is pending or in service.

Function
REQ-011 FSM states SHALL be IDLE, BUSY and DONE.
REQ-012 In IDLE, busywait SHALL equal (read | write) combinationally, so the cache never samples a false low on its first wait cycle.
REQ-013 IDLE with read or write at a rising edge SHALL latch address, writedata and operation, load counter with ACCESS_CYCLES-1, and go to BUSY.
REQ-014 In BUSY, busywait SHALL be 1; counter non-zero: decrement; counter zero: perform access and go to DONE.
REQ-015 The access SHALL occur at edge E0+ACCESS_CYCLES, where E0 is the acceptance edge.
REQ-016 Read access: readdata <= array[latched address]; write access: array[latched address] <= latched writedata.
REQ-017 In DONE, busywait SHALL be 0 for exactly one cycle; the next edge SHALL return to IDLE without accepting a request at that edge.
REQ-018 Back-to-back request (write-back, then refill) presented in the cycle after DONE SHALL raise busywait combinationally and be accepted at the following edge.
REQ-019 readdata SHALL hold its value until the next completed read; writes SHALL NOT change readdata.
REQ-020 read and write both high at acceptance SHALL be treated as write; the read is dropped.
REQ-021 Inputs changing or deasserting during BUSY SHALL be ignored; the latched operation completes.
REQ-022 Counter SHALL be 4 bits; no wrap beyond zero.

Reset
REQ-023 reset low SHALL immediately force state IDLE, counter 0 and readdata 32'h0; busywait then follows REQ-012.
REQ-024 Reset mid-BUSY SHALL abort the operation; an aborted write SHALL NOT modify the array.

Configuration
REQ-025 With DATA_MEMORY_RESET_CLEAR_EN defined, reset SHALL clear all NUM_BLOCKS words to 32'h0.
REQ-026 Without DATA_MEMORY_RESET_CLEAR_EN, array contents SHALL persist across reset and be uninitialised at time zero.

Structure
REQ-027 Shared package data_memory_pkg SHALL hold the state encoding (IDLE=2'b00, BUSY=2'b01, DONE=2'b10), address width 6, block width 32 and counter width 4.
REQ-028 The block SHALL contain no sub-module; storage array, counter and FSM are inline.

Verification (ACCESS_CYCLES=5, DATA_MEMORY_RESET_CLEAR_EN defined unless stated)
REQ-029 Write 32'hDEADBEEF to addr 6'h2A, then read 6'h2A -> busywait high 6 cycles per request; readdata=32'hDEADBEEF in read DONE cycle.
REQ-030 Write addr 6'h05, drop write after 1 cycle, immediately read 6'h05 in the cycle after DONE -> busywait never low between requests except the single DONE cycle; read returns the written data.
REQ-031 read=write=1 at addr 6'h10, data 32'h12345678 -> write performed, readdata unchanged; a later read returns 32'h12345678.
REQ-032 Write 32'hA5A5A5A5 to 6'h3F, assert reset at E0+3 -> FSM IDLE immediately, readdata 0; array[6'h3F] reads 0 (cleared).
REQ-033 Without macro: write 32'hCAFEF00D to 6'h01, pulse reset, read 6'h01 -> 32'hCAFEF00D.
REQ-034 ACCESS_CYCLES=1: read 6'h00 after reset clear -> busywait high 2 cycles, readdata 32'h0, DONE for exactly one cycle.
